led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised multi-channel LED driver and the successor to the single free-running blink counter. A shared prescaler and phase counter drive NUM_CH outputs. Each output has its own mode: off, on, blink at a selectable rate, or PWM dim. The block sits between the board clock input and the LED pins, and a simple write port configures it from control logic or fixed tie-offs.

## Interface
Parameters:
- NUM_CH, 4, number of LED channels (1..16)
- CH_SEL_W, 2, width of the channel select; must satisfy 2^CH_SEL_W >= NUM_CH
- PRESC_W, 20, prescaler width; one phase step every 2^PRESC_W clocks
- PHASE_W, 16, phase counter width; blink rate select spans 0..PHASE_W-1
- DUTY_W, 8, PWM resolution

Ports:
- CLOCK_IN  in  1  sole clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- CFG_WE  in  1  config write strobe, one cycle per write
- CFG_CH  in  CH_SEL_W  channel index being written
- CFG_MODE  in  2  0=off, 1=on, 2=blink, 3=PWM
- CFG_RATE  in  4  blink bit select into the phase counter
- CFG_DUTY  in  DUTY_W  PWM duty
- CFG_SYNC  in  1  one-cycle pulse that realigns all timebases
- LED_OUT  out  NUM_CH  registered LED drives
- TICK  out  1  registered one-cycle pulse per phase step

## Operation
- presc: PRESC_W-bit counter that increments every clock and wraps from all-ones to 0.
- phase: PHASE_W-bit counter that increments on the edge where presc == all-ones, and wraps.
- pwm_cnt: DUTY_W-bit counter that increments every clock and wraps.
- Per-channel config registers hold mode[1:0], rate[3:0] and duty[DUTY_W-1:0].
- Config write:
  - When CFG_WE=1 and CFG_CH < NUM_CH, the selected channel's registers load at that edge.
  - When CFG_CH >= NUM_CH, the write is ignored with no side effects.
- LED_OUT[i] next value:
  - mode 0 gives 0.
  - mode 1 gives 1.
  - mode 2 gives phase[rate]. A rate >= PHASE_W is clamped to PHASE_W-1.
  - mode 3 gives (pwm_cnt < duty), unsigned. duty=0 is always off; duty=2^DUTY_W-1 is off for exactly 1 of every 2^DUTY_W clocks.
- TICK next value = (presc == all-ones).
- CFG_SYNC=1 clears presc, phase and pwm_cnt at that edge. Config registers are untouched.
- Priority:
  - RESET overrides CFG_SYNC and CFG_WE.
  - CFG_SYNC and CFG_WE in the same cycle both take effect.

## Timing
- Reset values (one edge with RESET=1):
  - presc, phase and pwm_cnt are 0.
  - All channel configs are mode 0, rate 0, duty 0.
  - LED_OUT = 0 and TICK = 0.
- Reset mid-operation: every counter and config returns to its reset value at that edge, with no partial state. LED_OUT is 0 on the following cycle.
- Output latency: LED_OUT and TICK are registered and reflect counter and config state from the previous cycle.
- A config write at edge N changes LED_OUT at edge N+1.
- TICK:
  - Rises at the edge where presc wraps to 0, so it is high while presc == 0.
  - Period is exactly 2^PRESC_W clocks.
  - A sync that lands on a wrap cycle still produces TICK.
- Blink period for rate r is 2^(PRESC_W+r+1) clocks at 50% duty.
- PWM:
  - Period is 2^DUTY_W clocks.
  - The high time is duty clocks, starting at pwm_cnt=0.
- After CFG_SYNC at edge N, presc==1 at edge N+1. With an identical rate, channels in mode 2 are phase-aligned.
- Width rules: all counters wrap modulo 2^width and generate no carry-out. Comparisons are unsigned.

## Test plan
Bench uses PRESC_W=4, PHASE_W=8, DUTY_W=4, NUM_CH=4.
- Reset, then 40 idle clocks -> LED_OUT=4'b0000 throughout; TICK pulses at cycles 16 and 32 after reset release, one cycle wide each.
- Write ch0 mode 1, ch1 mode 2 rate 0, ch2 mode 3 duty 4 -> ch0 high from the next cycle; ch1 toggles every 16 clocks; ch2 high for 4 of every 16 clocks.
- PWM bounds: ch3 duty 0 -> never high over 64 clocks. Then ch3 duty 15 -> low exactly 1 clock per 16.
- Write with CFG_CH=3 at NUM_CH=3 -> no output or config changes (repeat at NUM_CH=4 to confirm the write lands). Rate=12 with PHASE_W=8 -> behaves as rate 7.
- CFG_SYNC asserted mid-period together with a CFG_WE to ch1 -> counters restart from 0, TICK next comes 16 clocks later, and the ch1 config is applied.
- RESET asserted during active blink/PWM with CFG_WE also high -> config is discarded, all outputs 0 on the next cycle, and counters restart.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared prescaler/phase/PWM timebase feeding
// per-channel off/on/blink/PWM selection, with registered outputs.
module led_pattern_gen #(
  parameter int NUM_CH   = 4,
  parameter int CH_SEL_W = 2,
  parameter int PRESC_W  = 20,
  parameter int PHASE_W  = 16,
  parameter int DUTY_W   = 8
) (
  input  logic                CLOCK_IN,
  input  logic                RESET,
  input  logic                CFG_WE,
  input  logic [CH_SEL_W-1:0] CFG_CH,
  input  logic [1:0]          CFG_MODE,
  input  logic [3:0]          CFG_RATE,
  input  logic [DUTY_W-1:0]   CFG_DUTY,
  input  logic                CFG_SYNC,
  output logic [NUM_CH-1:0]   LED_OUT,
  output logic                TICK
);

  localparam logic [PRESC_W-1:0] PRESC_ONE = 1;
  localparam logic [PHASE_W-1:0] PHASE_ONE = 1;
  localparam logic [DUTY_W-1:0]  DUTY_ONE  = 1;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;

  logic [1:0]        mode_q [NUM_CH];
  logic [1:0]        mode_d [NUM_CH];
  logic [3:0]        rate_q [NUM_CH];
  logic [3:0]        rate_d [NUM_CH];
  logic [DUTY_W-1:0] duty_q [NUM_CH];
  logic [DUTY_W-1:0] duty_d [NUM_CH];

  logic [NUM_CH-1:0] led_q, led_d;
  logic              tick_q, tick_d;
  logic [NUM_CH-1:0] blink_bit;

  // Rates beyond the phase counter saturate to its slowest bit.
  function automatic int rate_sel(input logic [3:0] r);
    if (int'(r) >= PHASE_W) return PHASE_W - 1;
    return int'(r);
  endfunction

  always_comb begin
    presc_d   = presc_q + PRESC_ONE;
    phase_d   = (&presc_q) ? phase_q + PHASE_ONE : phase_q;
    pwm_cnt_d = pwm_cnt_q + DUTY_ONE;
    tick_d    = &presc_q;
    if (CFG_SYNC) begin
      presc_d   = '0;
      phase_d   = '0;
      pwm_cnt_d = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i] = mode_q[i];
      rate_d[i] = rate_q[i];
      duty_d[i] = duty_q[i];
      if (CFG_WE && (CFG_CH == CH_SEL_W'(i))) begin
        mode_d[i] = CFG_MODE;
        rate_d[i] = CFG_RATE;
        duty_d[i] = CFG_DUTY;
      end
    end
  end

  always_comb begin
    blink_bit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = 0; j < PHASE_W; j++) begin
        if (rate_sel(rate_q[i]) == j) blink_bit[i] = phase_q[j];
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (mode_q[i])
        2'd0:    led_d[i] = 1'b0;
        2'd1:    led_d[i] = 1'b1;
        2'd2:    led_d[i] = blink_bit[i];
        default: led_d[i] = (pwm_cnt_q < duty_q[i]);
      endcase
    end
  end

  always_ff @(posedge CLOCK_IN) begin
    if (RESET) begin
      presc_q   <= '0;
      phase_q   <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
      tick_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= '0;
        rate_q[i] <= '0;
        duty_q[i] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      tick_q    <= tick_d;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= mode_d[i];
        rate_q[i] <= rate_d[i];
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign LED_OUT = led_q;
  assign TICK    = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a time-since-sync reference model
// predicts every output; a 3-channel copy checks out-of-range writes.
module tb_led_pattern_gen;

  localparam int PRESC_W = 4;
  localparam int PHASE_W = 8;
  localparam int DUTY_W  = 4;

  logic       clk = 1'b0;
  logic       reset, cfg_we, cfg_we_b, cfg_sync;
  logic [2:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_rate, cfg_duty;
  logic [3:0] led_a;
  logic [2:0] led_b;
  logic       tick_a, tick_b;

  // The 3-channel copy only sees writes that fit its 2-bit select.
  assign cfg_we_b = cfg_we && (cfg_ch < 3'd4);

  led_pattern_gen #(.NUM_CH(4), .CH_SEL_W(3), .PRESC_W(PRESC_W), .PHASE_W(PHASE_W), .DUTY_W(DUTY_W)) dut_a (
    .CLOCK_IN(clk), .RESET(reset), .CFG_WE(cfg_we), .CFG_CH(cfg_ch), .CFG_MODE(cfg_mode),
    .CFG_RATE(cfg_rate), .CFG_DUTY(cfg_duty), .CFG_SYNC(cfg_sync), .LED_OUT(led_a), .TICK(tick_a));

  led_pattern_gen #(.NUM_CH(3), .CH_SEL_W(2), .PRESC_W(PRESC_W), .PHASE_W(PHASE_W), .DUTY_W(DUTY_W)) dut_b (
    .CLOCK_IN(clk), .RESET(reset), .CFG_WE(cfg_we_b), .CFG_CH(cfg_ch[1:0]), .CFG_MODE(cfg_mode),
    .CFG_RATE(cfg_rate), .CFG_DUTY(cfg_duty), .CFG_SYNC(cfg_sync), .LED_OUT(led_b), .TICK(tick_b));

  always #5 clk = ~clk;

  int unsigned m_t;
  int m_mode [4];
  int m_rate [4];
  int m_duty [4];
  logic [4:0] exp_q [$];
  int n_checks = 0, n_fail = 0, n_pushed = 0, n_popped = 0;
  int win_ticks;
  int win_high [4];
  logic [3:0] win_led_or;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: sample the previous edge, drive inputs, predict the next edge.
  task automatic applyStimulus(input logic rst, input logic we, input int ch, input int mode,
                               input int rate, input int duty, input logic sync);
    logic [4:0] e;
    int r;
    @(negedge clk);
    win_ticks += int'(tick_a);
    win_led_or |= led_a;
    for (int i = 0; i < 4; i++) if (led_a[i] === 1'b1) win_high[i]++;
    reset = rst; cfg_we = we; cfg_ch = ch[2:0]; cfg_mode = mode[1:0];
    cfg_rate = rate[3:0]; cfg_duty = duty[3:0]; cfg_sync = sync;
    e = '0;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        case (m_mode[i])
          0: e[i] = 1'b0;
          1: e[i] = 1'b1;
          2: begin
            r = (m_rate[i] > PHASE_W - 1) ? PHASE_W - 1 : m_rate[i];
            e[i] = ((m_t >> (PRESC_W + r)) & 1) != 0;
          end
          default: e[i] = (m_t % (1 << DUTY_W)) < m_duty[i];
        endcase
      end
      e[4] = (m_t % (1 << PRESC_W)) == (1 << PRESC_W) - 1;
    end
    exp_q.push_back(e);
    n_pushed++;
    if (rst) begin
      m_t = 0;
      for (int i = 0; i < 4; i++) begin m_mode[i] = 0; m_rate[i] = 0; m_duty[i] = 0; end
    end else begin
      if (we && ch < 4) begin m_mode[ch] = mode; m_rate[ch] = rate; m_duty[ch] = duty; end
      m_t = sync ? 0 : (m_t + 1) % (1 << (PRESC_W + PHASE_W));
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic write(input int ch, input int mode, input int rate, input int duty);
    applyStimulus(1'b0, 1'b1, ch, mode, rate, duty, 1'b0);
  endtask

  // Counts outputs over the next n edges, excluding the edge just issued.
  task automatic runWindow(input int n);
    idle();
    win_ticks = 0; win_led_or = '0;
    for (int i = 0; i < 4; i++) win_high[i] = 0;
    repeat (n) idle();
  endtask

  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_popped++;
        checkOutput("led_a", 32'(led_a), 32'(e[3:0]));
        checkOutput("tick_a", 32'(tick_a), 32'(e[4]));
        checkOutput("led_b", 32'(led_b), 32'(e[2:0]));
        checkOutput("tick_b", 32'(tick_b), 32'(e[4]));
      end
    end
  end

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_rate = '0; cfg_duty = '0; cfg_sync = 1'b0;
    m_t = 0;
    for (int i = 0; i < 4; i++) begin m_mode[i] = 0; m_rate[i] = 0; m_duty[i] = 0; end

    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    runWindow(40);
    checkOutput("idle_ticks", win_ticks, 2);
    checkOutput("idle_led", 32'(win_led_or), 0);

    write(0, 1, 0, 0);
    write(1, 2, 0, 0);
    write(2, 3, 0, 4);
    runWindow(64);
    checkOutput("ch0_on", win_high[0], 64);
    checkOutput("ch1_blink", win_high[1], 32);
    checkOutput("ch2_pwm4", win_high[2], 16);

    write(3, 3, 0, 0);
    runWindow(64);
    checkOutput("ch3_duty0", win_high[3], 0);
    write(3, 3, 0, 15);
    runWindow(32);
    checkOutput("ch3_duty15", win_high[3], 30);

    write(3, 1, 0, 0);
    write(5, 1, 0, 0);
    write(6, 2, 3, 9);
    write(1, 2, 12, 0);
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    runWindow(2100);
    checkOutput("rate12_clamp", win_high[1], 52);

    repeat (7) idle();
    applyStimulus(1'b0, 1'b1, 1, 1, 0, 0, 1'b1);
    runWindow(16);
    checkOutput("sync_tick", win_ticks, 1);
    checkOutput("sync_write", win_high[1], 16);

    write(2, 3, 0, 9);
    write(0, 2, 1, 0);
    repeat (10) idle();
    applyStimulus(1'b1, 1'b1, 0, 1, 0, 0, 1'b1);
    runWindow(20);
    checkOutput("reset_led", 32'(win_led_or), 0);
    checkOutput("reset_tick", win_ticks, 1);

    for (int k = 0; k < 600; k++) begin
      applyStimulus($urandom_range(150) == 0, $urandom_range(3) == 0, $urandom_range(7),
                    $urandom_range(3), $urandom_range(15), $urandom_range(15),
                    $urandom_range(40) == 0);
    end

    @(posedge clk);
    #2;
    checkOutput("scoreboard_drain", n_popped, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
